// File: rtl/park_exit_ctrl.sv
// Parking-lot exit controller: decrypts an exit token into a slot number, frees
// the slot if occupied and pulses the gate, or counts failures towards a lockout.
module park_exit_ctrl #(
  parameter int NUM_BITS    = 3,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 8,
  parameter int GATE_CYCLES = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_exit,
  input  logic [NUM_BITS-1:0]        i_token,
  input  logic [NUM_BITS-1:0]        i_pattern,
  input  logic                       i_park_in_valid,
  input  logic [NUM_BITS-1:0]        i_park_in_number,
  output logic [NUM_BITS-1:0]        o_park_number,
  output logic                       o_exit_ok,
  output logic                       o_exit_err,
  output logic                       o_gate_open,
  output logic                       o_locked,
  output logic                       o_busy,
  output logic [(1<<NUM_BITS)-1:0]   o_occupancy,
  output logic [NUM_BITS:0]          o_free_count,
  output logic [1:0]                 o_dbg_state
);

  localparam int SLOTS = 1 << NUM_BITS;
  localparam int FW    = (MAX_FAIL    < 1) ? 1 : $clog2(MAX_FAIL + 1);
  localparam int LW    = (LOCK_CYCLES < 1) ? 1 : $clog2(LOCK_CYCLES + 1);
  localparam int GW    = (GATE_CYCLES < 1) ? 1 : $clog2(GATE_CYCLES + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_GATE  = 2'd2;
  localparam logic [1:0] ST_LOCK  = 2'd3;

  // Handshake: i_exit is a request with no ready/ack. It is taken only on an
  // edge where o_busy=0 (IDLE); requests on any other edge are dropped, never queued.

  logic [1:0]          r_state;
  logic [NUM_BITS-1:0] r_dec;
  logic [SLOTS-1:0]    r_occ;
  logic [FW-1:0]       r_fail_cnt;
  logic [GW-1:0]       r_gate_cnt;
  logic [LW-1:0]       r_lock_cnt;
  logic [NUM_BITS-1:0] r_park_number;
  logic                r_exit_ok;
  logic                r_exit_err;

  logic                w_hit;
  logic [FW-1:0]       w_fail_inc;
  logic                w_fail_max;
  logic [SLOTS-1:0]    w_occ_next;
  logic [NUM_BITS:0]   w_free;

  assign w_hit      = r_occ[r_dec];
  assign w_fail_inc = r_fail_cnt + 1'b1;
  assign w_fail_max = (w_fail_inc == FW'(MAX_FAIL));

  // An entry event on the slot being freed in CHECK wins: the set is applied last.
  always_comb begin
    w_occ_next = r_occ;
    if (r_state == ST_CHECK && w_hit)
      w_occ_next[r_dec] = 1'b0;
    if (i_park_in_valid)
      w_occ_next[i_park_in_number] = 1'b1;
  end

  always_comb begin
    w_free = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (!r_occ[i])
        w_free = w_free + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_occ <= '0;
    end else begin
      r_occ <= w_occ_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_dec         <= '0;
      r_fail_cnt    <= '0;
      r_gate_cnt    <= '0;
      r_lock_cnt    <= '0;
      r_park_number <= '0;
      r_exit_ok     <= 1'b0;
      r_exit_err    <= 1'b0;
    end else begin
      r_park_number <= '0;
      r_exit_ok     <= 1'b0;
      r_exit_err    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_exit) begin
            r_dec   <= i_token ^ i_pattern;
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_hit) begin
            r_fail_cnt    <= '0;
            r_park_number <= r_dec;
            r_exit_ok     <= 1'b1;
            r_gate_cnt    <= GW'(GATE_CYCLES);
            r_state       <= ST_GATE;
          end else begin
            r_exit_err <= 1'b1;
            if (w_fail_max) begin
              r_fail_cnt <= '0;
              r_lock_cnt <= LW'(LOCK_CYCLES);
              r_state    <= ST_LOCK;
            end else begin
              r_fail_cnt <= w_fail_inc;
              r_state    <= ST_IDLE;
            end
          end
        end
        ST_GATE: begin
          // The count is the number of GATE cycles still owed, including this one.
          if (r_gate_cnt <= GW'(1)) begin
            r_gate_cnt <= '0;
            r_state    <= ST_IDLE;
          end else begin
            r_gate_cnt <= r_gate_cnt - 1'b1;
          end
        end
        ST_LOCK: begin
          if (r_lock_cnt <= LW'(1)) begin
            r_lock_cnt <= '0;
            r_state    <= ST_IDLE;
          end else begin
            r_lock_cnt <= r_lock_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_park_number = r_park_number;
  assign o_exit_ok     = r_exit_ok;
  assign o_exit_err    = r_exit_err;
  assign o_gate_open   = (r_state == ST_GATE);
  assign o_locked      = (r_state == ST_LOCK);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_occupancy   = r_occ;
  assign o_free_count  = w_free;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_park_exit_ctrl.sv
// Directed vector bench for park_exit_ctrl: one table-driven run plus hand-written
// sequences for same-cycle set/clear, exit during GATE and asynchronous reset.
module tb_park_exit_ctrl;

  logic       clk;
  logic       rst;
  logic       exit_i;
  logic [2:0] token;
  logic [2:0] pattern;
  logic       piv;
  logic [2:0] pin;
  logic [2:0] park_number;
  logic       exit_ok;
  logic       exit_err;
  logic       gate_open;
  logic       locked;
  logic       busy;
  logic [7:0] occupancy;
  logic [3:0] free_count;
  logic [1:0] dbg_state;

  int n_vec;
  int n_err;

  typedef struct {
    string      name;
    logic       exit_v;
    logic [2:0] tok;
    logic [2:0] pat;
    logic       piv_v;
    logic [2:0] pin_v;
    logic       ok;
    logic       err;
    logic [2:0] pn;
    logic       gate;
    logic       lock;
    logic       bsy;
    logic [7:0] occ;
    logic [3:0] free;
  } vec_t;

  vec_t tbl[$];

  park_exit_ctrl #(
    .NUM_BITS(3), .MAX_FAIL(3), .LOCK_CYCLES(8), .GATE_CYCLES(4)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_exit(exit_i), .i_token(token), .i_pattern(pattern),
    .i_park_in_valid(piv), .i_park_in_number(pin),
    .o_park_number(park_number), .o_exit_ok(exit_ok), .o_exit_err(exit_err),
    .o_gate_open(gate_open), .o_locked(locked), .o_busy(busy),
    .o_occupancy(occupancy), .o_free_count(free_count), .o_dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(string name, logic ex, logic [2:0] tk, logic [2:0] pt,
                              logic pv, logic [2:0] pn_in, logic ok, logic err,
                              logic [2:0] pn, logic gate, logic lock, logic bsy,
                              logic [7:0] occ, logic [3:0] free);
    vec_t v;
    v.name = name; v.exit_v = ex; v.tok = tk; v.pat = pt; v.piv_v = pv; v.pin_v = pn_in;
    v.ok = ok; v.err = err; v.pn = pn; v.gate = gate; v.lock = lock; v.bsy = bsy;
    v.occ = occ; v.free = free;
    return v;
  endfunction

  // Idle-input vector: only expected outputs vary.
  function automatic vec_t idl(string name, logic ok, logic err, logic [2:0] pn,
                               logic gate, logic lock, logic bsy, logic [7:0] occ,
                               logic [3:0] free);
    return mk(name, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, ok, err, pn, gate, lock, bsy, occ, free);
  endfunction

  task automatic check_outputs(input vec_t v);
    n_vec++;
    if (exit_ok !== v.ok || exit_err !== v.err || park_number !== v.pn ||
        gate_open !== v.gate || locked !== v.lock || busy !== v.bsy ||
        occupancy !== v.occ || free_count !== v.free) begin
      n_err++;
      $display("FAIL %s: got ok=%b err=%b pn=%0d gate=%b lock=%b busy=%b occ=%02h free=%0d, want ok=%b err=%b pn=%0d gate=%b lock=%b busy=%b occ=%02h free=%0d",
               v.name, exit_ok, exit_err, park_number, gate_open, locked, busy, occupancy,
               free_count, v.ok, v.err, v.pn, v.gate, v.lock, v.bsy, v.occ, v.free);
    end
  endtask

  // Driver: apply inputs, take one rising edge, sample 1 time unit later.
  task automatic apply_vec(input vec_t v);
    exit_i  = v.exit_v;
    token   = v.tok;
    pattern = v.pat;
    piv     = v.piv_v;
    pin     = v.pin_v;
    @(posedge clk);
    #1;
    check_outputs(v);
  endtask

  task automatic pulse_reset_check(input string name);
    #1 rst = 1'b1;
    #1 check_outputs(idl(name, 0, 0, 3'd0, 0, 0, 0, 8'h00, 4'd8));
    #1 rst = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; exit_i = 1'b0; token = '0; pattern = '0; piv = 1'b0; pin = '0;
    #3;
    check_outputs(idl("reset_state", 0, 0, 3'd0, 0, 0, 0, 8'h00, 4'd8));
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b0;

    // Enter slot 5, exit with 6^3=5, then three failures to slot 2 and lockout.
    tbl.push_back(mk("enter5",    0, 3'd0, 3'd0, 1, 3'd5, 0, 0, 3'd0, 0, 0, 0, 8'h20, 4'd7));
    tbl.push_back(mk("exit5_req", 1, 3'd6, 3'd3, 0, 3'd0, 0, 0, 3'd0, 0, 0, 1, 8'h20, 4'd7));
    tbl.push_back(idl("exit5_ok",  1, 0, 3'd5, 1, 0, 1, 8'h00, 4'd8));
    tbl.push_back(idl("gate_c2",   0, 0, 3'd0, 1, 0, 1, 8'h00, 4'd8));
    tbl.push_back(idl("gate_c3",   0, 0, 3'd0, 1, 0, 1, 8'h00, 4'd8));
    tbl.push_back(idl("gate_c4",   0, 0, 3'd0, 1, 0, 1, 8'h00, 4'd8));
    tbl.push_back(idl("gate_done", 0, 0, 3'd0, 0, 0, 0, 8'h00, 4'd8));
    tbl.push_back(mk("fail1_req", 1, 3'd2, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 0, 1, 8'h00, 4'd8));
    tbl.push_back(idl("fail1_err", 0, 1, 3'd0, 0, 0, 0, 8'h00, 4'd8));
    tbl.push_back(mk("fail2_req", 1, 3'd2, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 0, 1, 8'h00, 4'd8));
    tbl.push_back(idl("fail2_err", 0, 1, 3'd0, 0, 0, 0, 8'h00, 4'd8));
    tbl.push_back(mk("fail3_req", 1, 3'd2, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 0, 1, 8'h00, 4'd8));
    tbl.push_back(mk("fail3_lock", 1, 3'd2, 3'd0, 0, 3'd0, 0, 1, 3'd0, 0, 1, 1, 8'h00, 4'd8));
    for (int i = 2; i <= 8; i++)
      tbl.push_back(mk($sformatf("lock_c%0d", i), 1, 3'd2, 3'd0, 0, 3'd0,
                       0, 0, 3'd0, 0, 1, 1, 8'h00, 4'd8));
    tbl.push_back(mk("lock_done", 1, 3'd2, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 8'h00, 4'd8));
    tbl.push_back(mk("enter3",    0, 3'd0, 3'd0, 1, 3'd3, 0, 0, 3'd0, 0, 0, 0, 8'h08, 4'd7));
    tbl.push_back(mk("exit3_req", 1, 3'd3, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 0, 1, 8'h08, 4'd7));
    tbl.push_back(idl("exit3_ok",  1, 0, 3'd3, 1, 0, 1, 8'h00, 4'd8));
    tbl.push_back(idl("gate3_c2",  0, 0, 3'd0, 1, 0, 1, 8'h00, 4'd8));
    tbl.push_back(idl("gate3_c3",  0, 0, 3'd0, 1, 0, 1, 8'h00, 4'd8));
    tbl.push_back(idl("gate3_c4",  0, 0, 3'd0, 1, 0, 1, 8'h00, 4'd8));
    tbl.push_back(idl("gate3_done", 0, 0, 3'd0, 0, 0, 0, 8'h00, 4'd8));
    foreach (tbl[i]) apply_vec(tbl[i]);

    // Two failures, a success, two failures: the success clears the fail count.
    apply_vec(mk("s3_enter6", 0, 3'd0, 3'd0, 1, 3'd6, 0, 0, 3'd0, 0, 0, 0, 8'h40, 4'd7));
    for (int k = 0; k < 2; k++) begin
      apply_vec(mk("s3_fail_req", 1, 3'd7, 3'd5, 0, 3'd0, 0, 0, 3'd0, 0, 0, 1, 8'h40, 4'd7));
      apply_vec(idl("s3_fail_err", 0, 1, 3'd0, 0, 0, 0, 8'h40, 4'd7));
    end
    apply_vec(mk("s3_exit6_req", 1, 3'd4, 3'd2, 0, 3'd0, 0, 0, 3'd0, 0, 0, 1, 8'h40, 4'd7));
    apply_vec(idl("s3_exit6_ok", 1, 0, 3'd6, 1, 0, 1, 8'h00, 4'd8));
    for (int k = 0; k < 3; k++)
      apply_vec(idl("s3_gate", 0, 0, 3'd0, 1, 0, 1, 8'h00, 4'd8));
    apply_vec(idl("s3_gate_done", 0, 0, 3'd0, 0, 0, 0, 8'h00, 4'd8));
    for (int k = 0; k < 2; k++) begin
      apply_vec(mk("s3_post_req", 1, 3'd2, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 0, 1, 8'h00, 4'd8));
      apply_vec(idl("s3_post_err_nolock", 0, 1, 3'd0, 0, 0, 0, 8'h00, 4'd8));
    end
    apply_vec(idl("s3_still_idle", 0, 0, 3'd0, 0, 0, 0, 8'h00, 4'd8));

    // Entry to slot 1 in the same cycle that CHECK frees slot 1: the set wins.
    apply_vec(mk("s4_enter1", 0, 3'd0, 3'd0, 1, 3'd1, 0, 0, 3'd0, 0, 0, 0, 8'h02, 4'd7));
    apply_vec(mk("s4_exit1_req", 1, 3'd5, 3'd4, 0, 3'd0, 0, 0, 3'd0, 0, 0, 1, 8'h02, 4'd7));
    apply_vec(mk("s4_set_wins", 0, 3'd0, 3'd0, 1, 3'd1, 1, 0, 3'd1, 1, 0, 1, 8'h02, 4'd7));
    for (int k = 0; k < 3; k++)
      apply_vec(idl("s4_gate", 0, 0, 3'd0, 1, 0, 1, 8'h02, 4'd7));
    apply_vec(idl("s4_gate_done", 0, 0, 3'd0, 0, 0, 0, 8'h02, 4'd7));

    // Exit held high through GATE: one exit_ok, next request taken only from IDLE.
    apply_vec(mk("s5_exit1_req", 1, 3'd1, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 0, 1, 8'h02, 4'd7));
    apply_vec(mk("s5_exit1_ok", 1, 3'd1, 3'd0, 0, 3'd0, 1, 0, 3'd1, 1, 0, 1, 8'h00, 4'd8));
    for (int k = 0; k < 3; k++)
      apply_vec(mk("s5_held_gate", 1, 3'd1, 3'd0, 0, 3'd0, 0, 0, 3'd0, 1, 0, 1, 8'h00, 4'd8));
    apply_vec(mk("s5_held_dropped", 1, 3'd1, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 8'h00, 4'd8));
    apply_vec(mk("s5_next_taken", 1, 3'd1, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 0, 1, 8'h00, 4'd8));
    apply_vec(idl("s5_next_err", 0, 1, 3'd0, 0, 0, 0, 8'h00, 4'd8));

    // Asynchronous reset mid-GATE.
    rst = 1'b1; #2 rst = 1'b0;
    apply_vec(mk("s6_enter4", 0, 3'd0, 3'd0, 1, 3'd4, 0, 0, 3'd0, 0, 0, 0, 8'h10, 4'd7));
    apply_vec(mk("s6_exit4_req", 1, 3'd4, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 0, 1, 8'h10, 4'd7));
    apply_vec(mk("s6_gate_enter1", 0, 3'd0, 3'd0, 1, 3'd2, 1, 0, 3'd4, 1, 0, 1, 8'h04, 4'd7));
    apply_vec(idl("s6_gate_mid", 0, 0, 3'd0, 1, 0, 1, 8'h04, 4'd7));
    pulse_reset_check("s6_reset_mid_gate");

    // Asynchronous reset mid-LOCK.
    apply_vec(mk("s6_enter0", 0, 3'd0, 3'd0, 1, 3'd0, 0, 0, 3'd0, 0, 0, 0, 8'h01, 4'd7));
    for (int k = 0; k < 3; k++) begin
      apply_vec(mk("s6_fail_req", 1, 3'd3, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 0, 1, 8'h01, 4'd7));
      if (k < 2)
        apply_vec(idl("s6_fail_err", 0, 1, 3'd0, 0, 0, 0, 8'h01, 4'd7));
      else
        apply_vec(idl("s6_fail_lock", 0, 1, 3'd0, 0, 1, 1, 8'h01, 4'd7));
    end
    apply_vec(idl("s6_lock_mid", 0, 0, 3'd0, 0, 1, 1, 8'h01, 4'd7));
    pulse_reset_check("s6_reset_mid_lock");
    apply_vec(idl("s6_after_reset", 0, 0, 3'd0, 0, 0, 0, 8'h00, 4'd8));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
